// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time, predicts statically
// and buffers fetched words in a circular FIFO presented to the Decoder.
module instr_fetch #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc,
  input  logic        Decoder_not_ready_accept,
  output logic        update_instr_valid,
  output logic [31:0] update_instr,
  output logic [31:0] update_instr_pc,
  output logic        update_instr_isjump,
  output logic [31:0] update_instr_jump_wrong_to_pc
);

  localparam int               PTR_W   = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = (PTR_W)'(1);
  localparam logic [6:0]       OP_JAL    = 7'b1101111;
  localparam logic [6:0]       OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  logic [31:0]       pc_r;
  logic              mem_req_r;
  logic [31:0]       mem_addr_r;
  logic [31:0]       q_instr_r [QUEUE_DEPTH];
  logic [31:0]       q_pc_r    [QUEUE_DEPTH];
  logic [31:0]       q_wrong_r [QUEUE_DEPTH];
  logic              q_jump_r  [QUEUE_DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [PTR_W:0]    count_r;

  logic              pred_taken_s;
  logic [31:0]       pred_next_s;
  logic [31:0]       pred_wrong_s;
  logic              push_s;
  logic              pop_s;
  logic              issue_s;

  function automatic logic [31:0] imm_j(input logic [31:0] w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  // Static predictor on the returning word; pc_r still holds the address of that request.
  always_comb begin
    pred_taken_s = 1'b0;
    pred_next_s  = pc_r + 32'd4;
    pred_wrong_s = pc_r + 32'd4;
    case (mem_resp_data[6:0])
      OP_JAL: begin
        pred_taken_s = 1'b1;
        pred_next_s  = pc_r + imm_j(mem_resp_data);
      end
      OP_BRANCH: begin
        if (mem_resp_data[31]) begin
          pred_taken_s = 1'b1;
          pred_next_s  = pc_r + imm_b(mem_resp_data);
        end else begin
          pred_wrong_s = pc_r + imm_b(mem_resp_data);
        end
      end
      default: begin
        pred_taken_s = 1'b0;
      end
    endcase
  end

  assign push_s  = rdy && (state_r == S_WAIT) && mem_resp_valid && !rob_flush;
  assign pop_s   = rdy && (count_r != '0) && !Decoder_not_ready_accept && !rob_flush;
  assign issue_s = (state_r == S_IDLE) && (count_r < DEPTH_C) && !rob_flush;

  // Fetch FSM, PC and registered memory request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      pc_r       <= RESET_PC;
      mem_req_r  <= 1'b0;
      mem_addr_r <= RESET_PC;
    end else if (rdy) begin
      if (rob_flush) begin
        pc_r <= rob_flush_pc;
      end else if (state_r == S_WAIT && mem_resp_valid) begin
        pc_r <= pred_next_s;
      end
      case (state_r)
        S_IDLE: begin
          if (issue_s) begin
            state_r    <= S_WAIT;
            mem_req_r  <= 1'b1;
            mem_addr_r <= pc_r;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state_r   <= S_IDLE;
            mem_req_r <= 1'b0;
          end else if (rob_flush) begin
            state_r   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_resp_valid) begin
            state_r   <= S_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Instruction FIFO; a flush discards everything including a same-cycle push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_instr_r[i] <= 32'h0;
        q_pc_r[i]    <= 32'h0;
        q_wrong_r[i] <= 32'h0;
        q_jump_r[i]  <= 1'b0;
      end
    end else if (rdy) begin
      if (rob_flush) begin
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
      end else begin
        if (push_s) begin
          q_instr_r[tail_r] <= mem_resp_data;
          q_pc_r[tail_r]    <= pc_r;
          q_wrong_r[tail_r] <= pred_wrong_s;
          q_jump_r[tail_r]  <= pred_taken_s;
          tail_r            <= tail_r + PTR_ONE;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_ONE;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_ONE;
          2'b01:   count_r <= count_r - CNT_ONE;
          default: count_r <= count_r;
        endcase
      end
    end
  end

  assign mem_req                       = mem_req_r;
  assign mem_addr                      = mem_addr_r;
  assign update_instr_valid            = (count_r != '0);
  assign update_instr                  = q_instr_r[head_r];
  assign update_instr_pc               = q_pc_r[head_r];
  assign update_instr_isjump           = q_jump_r[head_r];
  assign update_instr_jump_wrong_to_pc = q_wrong_r[head_r];

endmodule
